// File: rtl/tc_uart_port_if.sv
`default_nettype none
// ============================================================================
//  Module      : tc_uart_port_if
//  Description : TinyComp I/O bus bundle between the CPU (master) and an
//                I/O responder (slave).
//                  IOaddr    - I/O address, CPU -> device
//                  OutData   - write data, CPU -> device
//                  OutStrobe - Output instruction executing this cycle
//                  InStrobe  - Input instruction executing this cycle
//                  InData    - read data, device -> CPU (combinational)
//                  InRdy     - skip-test status, device -> CPU (combinational)
//  Revision    : 1.0 - initial release
// ============================================================================
interface tc_uart_port_if;
    logic [31:0] IOaddr;
    logic [31:0] OutData;
    logic        OutStrobe;
    logic        InStrobe;
    logic [31:0] InData;
    logic        InRdy;

    modport master (
        output IOaddr, OutData, OutStrobe, InStrobe,
        input  InData, InRdy
    );

    modport slave (
        input  IOaddr, OutData, OutStrobe, InStrobe,
        output InData, InRdy
    );
endinterface
`default_nettype wire

// File: rtl/tc_uart_port.sv
`default_nettype none
// ============================================================================
//  Module      : tc_uart_port
//  Description : 8N1 UART responder on the TinyComp I/O bus. TX and RX FIFOs,
//                programmable bit divisor, sticky error flags. Register reads
//                are combinational within the instruction; all state commits
//                on the Ph0 edge that ends it.
//  Ports       : Ph0      - clock, one CPU instruction per cycle
//                Reset_n  - asynchronous active-low reset
//                bus      - I/O bus, slave side (IOaddr/OutData/strobes in,
//                           InData/InRdy out)
//                txd      - serial out, idle high
//                rxd      - serial in, asynchronous to Ph0
//  Registers   : 0 DATA, 1 STATUS, 2 DIV, 3 CTRL
//  Revision    : 1.0 - initial release
// ============================================================================
module tc_uart_port #(
    parameter logic [27:0] BASE       = 28'h0000001,
    parameter int          FIFO_DEPTH = 4,
    parameter logic [15:0] DIV_RESET  = 16'd434
) (
    input  logic            Ph0,
    input  logic            Reset_n,
    tc_uart_port_if.slave   bus,
    output logic            txd,
    input  logic            rxd
);

    localparam int         AW       = $clog2(FIFO_DEPTH);
    localparam logic [4:0] FULL_CNT = 5'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_START = 2'd1,
        S_DATA  = 2'd2,
        S_STOP  = 2'd3
    } uart_state_t;

    // ---------------------------------------------------------------- decode
    logic       sel;
    logic [3:0] regsel;
    logic       rd_en;
    logic       wr_en;
    logic       unused_bits;

    assign sel    = (bus.IOaddr[31:4] == BASE);
    assign regsel = bus.IOaddr[3:0];
    assign rd_en  = sel && bus.InStrobe;
    // A simultaneous InStrobe wins: the Output half of the access is ignored.
    assign wr_en  = sel && bus.OutStrobe && !bus.InStrobe;
    assign unused_bits = ^bus.OutData[31:16];

    // ------------------------------------------------------- config / flags
    logic [15:0] divisor;
    logic [15:0] eff_div;
    logic [15:0] bit_reload;
    logic [15:0] half_reload;
    logic        rx_overrun;
    logic        rx_frame_err;
    logic        tx_drop;
    logic        flag_clr;

    assign eff_div     = (divisor < 16'd4) ? 16'd4 : divisor;
    assign bit_reload  = eff_div - 16'd1;
    assign half_reload = {1'b0, eff_div[15:1]} - 16'd1;
    assign flag_clr    = wr_en && (regsel == 4'd3) && bus.OutData[0];

    // ---------------------------------------------------------------- FIFOs
    logic [7:0]    tx_mem [FIFO_DEPTH];
    logic [AW-1:0] tx_wptr, tx_rptr;
    logic [4:0]    tx_count;
    logic          tx_full, tx_empty, tx_push, tx_pop, tx_drop_set;

    logic [7:0]    rx_mem [FIFO_DEPTH];
    logic [AW-1:0] rx_wptr, rx_rptr;
    logic [4:0]    rx_count;
    logic          rx_full, rx_empty, rx_push, rx_pop;

    assign tx_full     = (tx_count == FULL_CNT);
    assign tx_empty    = (tx_count == 5'd0);
    assign tx_push     = wr_en && (regsel == 4'd0) && !tx_full;
    assign tx_drop_set = wr_en && (regsel == 4'd0) && tx_full;

    assign rx_full  = (rx_count == FULL_CNT);
    assign rx_empty = (rx_count == 5'd0);
    assign rx_pop   = rd_en && (regsel == 4'd0) && !rx_empty;

    // ---------------------------------------------------------------- TX FSM
    uart_state_t tx_state, tx_state_next;
    logic [15:0] tx_cnt;
    logic [2:0]  tx_bit;
    logic [7:0]  tx_shreg;
    logic        tx_tick, tx_load, tx_shift;

    assign tx_tick = (tx_cnt == 16'd0);

    always_ff @(posedge Ph0 or negedge Reset_n) begin
        if (!Reset_n) tx_state <= S_IDLE;
        else          tx_state <= tx_state_next;
    end

    always_comb begin
        tx_state_next = tx_state;
        tx_pop        = 1'b0;
        tx_load       = 1'b0;
        tx_shift      = 1'b0;
        txd           = 1'b1;
        case (tx_state)
            S_IDLE: begin
                if (!tx_empty) begin
                    tx_pop        = 1'b1;
                    tx_load       = 1'b1;
                    tx_state_next = S_START;
                end
            end
            S_START: begin
                txd = 1'b0;
                if (tx_tick) begin
                    tx_load       = 1'b1;
                    tx_state_next = S_DATA;
                end
            end
            S_DATA: begin
                txd = tx_shreg[0];
                if (tx_tick) begin
                    tx_shift = 1'b1;
                    tx_load  = 1'b1;
                    if (tx_bit == 3'd7) tx_state_next = S_STOP;
                end
            end
            S_STOP: begin
                // Chain straight into the next start bit when more data waits.
                if (tx_tick) begin
                    if (!tx_empty) begin
                        tx_pop        = 1'b1;
                        tx_load       = 1'b1;
                        tx_state_next = S_START;
                    end else begin
                        tx_state_next = S_IDLE;
                    end
                end
            end
            default: tx_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge Ph0 or negedge Reset_n) begin
        if (!Reset_n) begin
            tx_cnt   <= 16'd0;
            tx_bit   <= 3'd0;
            tx_shreg <= 8'hFF;
        end else begin
            // Reload samples the divisor at each boundary, so a mid-frame
            // divisor write applies from the next bit on.
            if (tx_load)               tx_cnt <= bit_reload;
            else if (tx_cnt != 16'd0)  tx_cnt <= tx_cnt - 16'd1;
            if (tx_pop) begin
                tx_shreg <= tx_mem[tx_rptr];
                tx_bit   <= 3'd0;
            end else if (tx_shift) begin
                tx_shreg <= {1'b1, tx_shreg[7:1]};
                tx_bit   <= tx_bit + 3'd1;
            end
        end
    end

    // ---------------------------------------------------------------- RX FSM
    logic        rx_meta, rx_sync, rx_prev;
    uart_state_t rx_state, rx_state_next;
    logic [15:0] rx_cnt;
    logic [2:0]  rx_bit;
    logic [7:0]  rx_shreg;
    logic        rx_tick, rx_load_half, rx_load_full, rx_sample, rx_stop_sample;
    logic        rx_overrun_set, rx_frame_set;

    assign rx_tick = (rx_cnt == 16'd0);

    always_ff @(posedge Ph0 or negedge Reset_n) begin
        if (!Reset_n) begin
            rx_meta  <= 1'b1;
            rx_sync  <= 1'b1;
            rx_prev  <= 1'b1;
            rx_state <= S_IDLE;
        end else begin
            rx_meta  <= rxd;
            rx_sync  <= rx_meta;
            rx_prev  <= rx_sync;
            rx_state <= rx_state_next;
        end
    end

    always_comb begin
        rx_state_next  = rx_state;
        rx_load_half   = 1'b0;
        rx_load_full   = 1'b0;
        rx_sample      = 1'b0;
        rx_stop_sample = 1'b0;
        case (rx_state)
            S_IDLE: begin
                if (rx_prev && !rx_sync) begin
                    rx_load_half  = 1'b1;
                    rx_state_next = S_START;
                end
            end
            S_START: begin
                // Resample mid start bit; a high line here was a glitch.
                if (rx_tick) begin
                    if (rx_sync) begin
                        rx_state_next = S_IDLE;
                    end else begin
                        rx_load_full  = 1'b1;
                        rx_state_next = S_DATA;
                    end
                end
            end
            S_DATA: begin
                if (rx_tick) begin
                    rx_sample    = 1'b1;
                    rx_load_full = 1'b1;
                    if (rx_bit == 3'd7) rx_state_next = S_STOP;
                end
            end
            S_STOP: begin
                if (rx_tick) begin
                    rx_stop_sample = 1'b1;
                    rx_state_next  = S_IDLE;
                end
            end
            default: rx_state_next = S_IDLE;
        endcase
    end

    // A pop in the same cycle frees a slot, so full+pop still accepts.
    assign rx_push        = rx_stop_sample && rx_sync && (!rx_full || rx_pop);
    assign rx_overrun_set = rx_stop_sample && rx_sync && rx_full && !rx_pop;
    assign rx_frame_set   = rx_stop_sample && !rx_sync;

    always_ff @(posedge Ph0 or negedge Reset_n) begin
        if (!Reset_n) begin
            rx_cnt   <= 16'd0;
            rx_bit   <= 3'd0;
            rx_shreg <= 8'h00;
        end else begin
            if (rx_load_half)          rx_cnt <= half_reload;
            else if (rx_load_full)     rx_cnt <= bit_reload;
            else if (rx_cnt != 16'd0)  rx_cnt <= rx_cnt - 16'd1;
            if (rx_state == S_START) begin
                rx_bit <= 3'd0;
            end else if (rx_sample) begin
                rx_shreg <= {rx_sync, rx_shreg[7:1]};
                rx_bit   <= rx_bit + 3'd1;
            end
        end
    end

    // ------------------------------------------------------- FIFO storage
    always_ff @(posedge Ph0) begin
        if (tx_push) tx_mem[tx_wptr] <= bus.OutData[7:0];
        if (rx_push) rx_mem[rx_wptr] <= rx_shreg;
    end

    always_ff @(posedge Ph0 or negedge Reset_n) begin
        if (!Reset_n) begin
            tx_wptr  <= '0;
            tx_rptr  <= '0;
            tx_count <= 5'd0;
            rx_wptr  <= '0;
            rx_rptr  <= '0;
            rx_count <= 5'd0;
        end else begin
            if (tx_push) tx_wptr <= tx_wptr + AW'(1);
            if (tx_pop)  tx_rptr <= tx_rptr + AW'(1);
            if (tx_push && !tx_pop)      tx_count <= tx_count + 5'd1;
            else if (!tx_push && tx_pop) tx_count <= tx_count - 5'd1;
            if (rx_push) rx_wptr <= rx_wptr + AW'(1);
            if (rx_pop)  rx_rptr <= rx_rptr + AW'(1);
            if (rx_push && !rx_pop)      rx_count <= rx_count + 5'd1;
            else if (!rx_push && rx_pop) rx_count <= rx_count - 5'd1;
        end
    end

    // --------------------------------------------------- config and flags
    always_ff @(posedge Ph0 or negedge Reset_n) begin
        if (!Reset_n) begin
            divisor      <= DIV_RESET;
            rx_overrun   <= 1'b0;
            rx_frame_err <= 1'b0;
            tx_drop      <= 1'b0;
        end else begin
            if (wr_en && (regsel == 4'd2)) divisor <= bus.OutData[15:0];
            // Set wins over a clear in the same cycle.
            rx_overrun   <= rx_overrun_set || (rx_overrun   && !flag_clr);
            rx_frame_err <= rx_frame_set   || (rx_frame_err && !flag_clr);
            tx_drop      <= tx_drop_set    || (tx_drop      && !flag_clr);
        end
    end

    // -------------------------------------------------------- read side
    logic [31:0] rd_data;
    logic        rd_rdy;

    always_comb begin
        rd_data = 32'd0;
        rd_rdy  = 1'b0;
        if (sel) begin
            case (regsel)
                4'd0: begin
                    rd_rdy  = !rx_empty;
                    rd_data = rx_empty ? 32'd0 : {24'd0, rx_mem[rx_rptr]};
                end
                4'd1: begin
                    rd_rdy  = !tx_full;
                    rd_data = {17'd0, tx_drop, rx_frame_err, rx_overrun, tx_full,
                               (tx_empty && (tx_state == S_IDLE)),
                               rx_count, tx_count};
                end
                4'd2: begin
                    rd_rdy  = 1'b1;
                    rd_data = {16'd0, divisor};
                end
                4'd3: begin
                    rd_rdy  = 1'b1;
                end
                default: begin
                    rd_rdy  = 1'b0;
                    rd_data = 32'd0;
                end
            endcase
        end
    end

    assign bus.InData = rd_data;
    assign bus.InRdy  = rd_rdy;

endmodule
`default_nettype wire
